// File: rtl/hamming74_pkg.sv
// hamming74_pkg: codeword field indices and shared Hamming(7,4) parity/syndrome/correction helpers
package hamming74_pkg;
    localparam int D0 = 0;
    localparam int D1 = 1;
    localparam int D2 = 2;
    localparam int D3 = 3;
    localparam int P0 = 4;
    localparam int P1 = 5;
    localparam int P2 = 6;

    function automatic logic [0:2] parity(input logic [0:3] d);
        return {d[0] ^ d[1] ^ d[3], d[0] ^ d[2] ^ d[3], d[1] ^ d[2] ^ d[3]};
    endfunction

    function automatic logic [0:6] encode(input logic [0:3] d);
        return {d, parity(d)};
    endfunction

    function automatic logic [0:2] calc_syndrome(input logic [0:6] c);
        return parity(c[D0:D3]) ^ c[P0:P2];
    endfunction

    function automatic logic [0:3] fix_mask(input logic [0:2] s);
        return s == 3'b110 ? 4'b1000 :
               s == 3'b101 ? 4'b0100 :
               s == 3'b011 ? 4'b0010 :
               s == 3'b111 ? 4'b0001 : 4'b0000;
    endfunction
endpackage

// File: rtl/hamming74_syndrome.sv
// hamming74_syndrome: applies the syndrome-selected correction mask to the data bits of a codeword
module hamming74_syndrome
    import hamming74_pkg::*;
(
    input  logic [0:6] code,
    input  logic [0:2] syn,
    output logic [0:3] data,
    output logic       err
);
    assign data = code[D0:D3] ^ fix_mask(syn);
    assign err  = |syn;
endmodule

// File: rtl/hamming74_decoder.sv
// hamming74_decoder: two-stage valid/ready Hamming(7,4) decoder with saturating word/correction counters
module hamming74_decoder
    import hamming74_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [0:6]       code_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [0:3]       data_out,
    output logic [0:2]       syndrome,
    output logic             err_flag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] corr_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic       s1_valid;
    logic [0:6] s1_code;
    logic [0:2] s1_syn;
    logic [0:3] fix_data;
    logic       fix_err;
    logic       s1_adv;
    logic       s2_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_adv;
    assign in_ready = !s1_valid || s2_adv;

    hamming74_syndrome u_syn (
        .code (s1_code),
        .syn  (s1_syn),
        .data (fix_data),
        .err  (fix_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_code   <= '0;
            s1_syn    <= '0;
            out_valid <= 1'b0;
            data_out  <= '0;
            syndrome  <= '0;
            err_flag  <= 1'b0;
            word_cnt  <= '0;
            corr_cnt  <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_code <= code_in;
                    s1_syn  <= calc_syndrome(code_in);
                end
            end
            if (s2_adv)
                out_valid <= s1_valid;
            if (s1_adv) begin
                data_out <= fix_data;
                syndrome <= s1_syn;
                err_flag <= fix_err;
            end
            if (out_valid && out_ready) begin
                if (word_cnt != CNT_MAX)
                    word_cnt <= word_cnt + 1'b1;
                if (err_flag && corr_cnt != CNT_MAX)
                    corr_cnt <= corr_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hamming74_decoder.sv
// tb_hamming74_decoder: directed vectors with hand-computed codewords, scoreboard on delivered words
module tb_hamming74_decoder;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [6:0]    code_in = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    data_out;
    logic [2:0]    syndrome;
    logic          err_flag;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [CW-1:0] word_cnt;
    logic [CW-1:0] corr_cnt;

    int total = 0;
    int bad = 0;
    int acc = 0;
    int cyc = 0;
    int c0, a0;
    logic [7:0] q[$];
    logic [7:0] e;
    logic [3:0] exp_d = '0;
    logic [2:0] exp_s = '0;
    logic       exp_e = 1'b0;

    // parity bits {p0,p1,p2} for nibble d0d1d2d3 = index
    logic [2:0] par [16] = '{3'b000, 3'b111, 3'b011, 3'b100, 3'b101, 3'b010, 3'b110, 3'b001,
                             3'b110, 3'b001, 3'b101, 3'b010, 3'b011, 3'b100, 3'b000, 3'b111};
    logic [6:0] err_code [8] = '{7'b1111010, 7'b1011110, 7'b1011011, 7'b0011010,
                                 7'b1010010, 7'b1001010, 7'b1011000, 7'b0000100};
    logic [3:0] err_data [8] = '{4'b1011, 4'b1011, 4'b1011, 4'b1011,
                                 4'b1011, 4'b1011, 4'b1011, 4'b0000};
    logic [2:0] err_syn  [8] = '{3'b101, 3'b100, 3'b001, 3'b110,
                                 3'b111, 3'b011, 3'b010, 3'b100};

    hamming74_decoder #(.CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .code_in   (code_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .syndrome  (syndrome),
        .err_flag  (err_flag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .word_cnt  (word_cnt),
        .corr_cnt  (corr_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("data", 32'(data_out), 32'(e[7:4]));
                    chk("syn", 32'(syndrome), 32'(e[3:1]));
                    chk("err", 32'(err_flag), 32'(e[0]));
                end
            end
            if (in_valid && in_ready) begin
                q.push_back({exp_d, exp_s, exp_e});
                acc++;
            end
        end
    end

    task automatic send(input logic [6:0] c, input logic [3:0] d, input logic [2:0] s, input logic er);
        int n = 0;
        code_in = c;
        exp_d = d;
        exp_s = s;
        exp_e = er;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while (!(q.size() == 0 && !out_valid) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(q.size() == 0 && !out_valid), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        do_reset();
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data", 32'(data_out), 0);
        chk("rst_syn", 32'(syndrome), 0);
        chk("rst_err", err_flag, 0);
        chk("rst_word_cnt", 32'(word_cnt), 0);
        chk("rst_corr_cnt", 32'(corr_cnt), 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        send(7'b1011010, 4'b1011, 3'b000, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_s1", out_valid, 0);
        @(negedge clk);
        chk("lat_s2", out_valid, 1);
        drain();
        c0 = cyc;
        for (int n = 0; n < 16; n++)
            send({4'(n), par[n]}, 4'(n), 3'b000, 1'b0);
        chk("throughput", 32'(cyc - c0), 16);
        in_valid = 1'b0;
        drain();
        chk("clean_word_sat", 32'(word_cnt), 7);
        chk("clean_corr", 32'(corr_cnt), 0);

        do_reset();
        send(err_code[0], err_data[0], err_syn[0], 1'b1);
        in_valid = 1'b0;
        drain();
        chk("derr_word", 32'(word_cnt), 1);
        chk("derr_corr", 32'(corr_cnt), 1);
        send(err_code[1], err_data[1], err_syn[1], 1'b1);
        in_valid = 1'b0;
        drain();
        chk("perr_word", 32'(word_cnt), 2);
        chk("perr_corr", 32'(corr_cnt), 2);
        send(7'b1011010, 4'b1011, 3'b000, 1'b0);
        in_valid = 1'b0;
        drain();
        chk("clean_word", 32'(word_cnt), 3);
        chk("clean_corr2", 32'(corr_cnt), 2);
        for (int i = 0; i < 10; i++)
            send(err_code[i % 8], err_data[i % 8], err_syn[i % 8], 1'b1);
        in_valid = 1'b0;
        drain();
        chk("sat_word", 32'(word_cnt), 7);
        chk("sat_corr", 32'(corr_cnt), 7);

        do_reset();
        out_ready = 1'b0;
        a0 = acc;
        fork
            begin
                send(7'b0001111, 4'b0001, 3'b000, 1'b0);
                send(7'b0010011, 4'b0010, 3'b000, 1'b0);
                send(7'b1111010, 4'b1011, 3'b101, 1'b1);
                in_valid = 1'b0;
            end
        join_none
        repeat (3) @(negedge clk);
        chk("bp_hold_a", 32'(data_out), 32'(4'b0001));
        repeat (2) @(negedge clk);
        chk("bp_accepted", 32'(acc - a0), 2);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_hold_b", 32'(data_out), 32'(4'b0001));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait fork;
        drain();
        chk("bp_total_acc", 32'(acc - a0), 3);
        chk("bp_word", 32'(word_cnt), 3);
        chk("bp_corr", 32'(corr_cnt), 1);

        out_ready = 1'b0;
        send(7'b1100011, 4'b1100, 3'b000, 1'b0);
        send(7'b0110110, 4'b0110, 3'b000, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        out_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_word", 32'(word_cnt), 0);
        chk("mid_rst_corr", 32'(corr_cnt), 0);
        chk("mid_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        send(7'b1011110, 4'b1011, 3'b100, 1'b1);
        in_valid = 1'b0;
        drain();
        chk("post_rst_word", 32'(word_cnt), 1);
        chk("post_rst_corr", 32'(corr_cnt), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hamming74_decoder.md
# hamming74_decoder

Receives 7-bit Hamming(7,4) codewords from the encoding stage, computes the 3-bit syndrome, corrects any single-bit error and delivers the recovered 4-bit nibble downstream. It is a two-stage pipeline with valid/ready flow control on both sides and saturating statistics counters. It sits directly after the encoder (and any channel/error-injection model) in the link datapath.

## Interface
- CNT_W, 16, width of the statistics counters

- clk  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high; clears pipeline and counters
- code_in  in  [0:6]  codeword {d0,d1,d2,d3,p0,p1,p2}
- in_valid  in  1  code_in valid
- in_ready  out  1  decoder can accept this cycle
- data_out  out  [0:3]  corrected nibble {d0,d1,d2,d3}
- syndrome  out  [0:2]  {s0,s1,s2} of the delivered word
- err_flag  out  1  syndrome nonzero (single-bit error corrected)
- out_valid  out  1  data_out/syndrome/err_flag valid
- out_ready  in  1  downstream accepts
- word_cnt  out  CNT_W  words delivered, saturating
- corr_cnt  out  CNT_W  words delivered with err_flag=1, saturating

## Operation
- Code definition: p0=d0^d1^d3, p1=d0^d2^d3, p2=d1^d2^d3.
- Syndrome: s0=p0^d0^d1^d3, s1=p1^d0^d2^d3, s2=p2^d1^d2^d3.
- Syndrome→flipped bit: 110→d0, 101→d1, 011→d2, 111→d3, 100→p0, 010→p1, 001→p2, 000→none.
- Correction flips only the indicated data bit; parity-bit errors leave data unchanged but still set err_flag.
- Double errors are miscorrected by design (no detection claim).
- Stage 1 (S1): registers code_in and its syndrome on input handshake (in_valid && in_ready).
- Stage 2 (S2): registers corrected nibble, syndrome, err_flag when S1 advances.
- Counters: on output handshake (out_valid && out_ready) word_cnt+1, and corr_cnt+1 if err_flag; each holds at 2^CNT_W−1.

## Timing
- Reset values: out_valid=0, data_out=0, syndrome=0, err_flag=0, word_cnt=0, corr_cnt=0; in_ready=1 from the first cycle after reset is released.
- Reset mid-operation: both pipeline valids cleared in the same edge; in-flight words discarded, not counted.
- Latency: word accepted at edge N appears with out_valid=1 after edge N+2.
- Throughput: one word per cycle while out_ready=1.
- s2_adv = !s2_valid || out_ready; s1_adv = s1_valid && s2_adv.
- in_ready = !s1_valid || s2_adv (combinational, no dependence on in_valid).
- Outputs hold stable while out_valid && !out_ready.
- Simultaneous output handshake and S1 advance: S2 reloads in the same edge, no bubble.
- Full: both stages valid and out_ready=0 → in_ready=0; at most 2 words buffered.
- Counters update only on output handshake; saturation checked before increment.

## Structure
- Package hamming74_pkg: codeword field index constants, parity and syndrome functions, syndrome→data-bit-mask function; the encoder is refactored to use the same parity function.
- One natural sub-module: hamming74_syndrome (combinational syndrome + correction mask), instantiated between S1 and S2.

## Test plan
- Clean stream: nibbles 0..15 encoded, e.g. 1011 → code_in 1011010, out_ready=1 → data_out 1011, syndrome 000, err_flag 0, out_valid 2 cycles after accept, one word per cycle.
- Data error: 1111010 (d1 flipped) → data_out 1011, syndrome 101, err_flag 1, corr_cnt +1.
- Parity error: 1011110 (p0 flipped) → data_out 1011, syndrome 100, err_flag 1.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 → exactly 2 words accepted, in_ready=0, data_out stable; on release, words delivered in order, none lost or duplicated.
- Reset mid-stream: reset pulsed with both stages full → next cycle out_valid=0, counters 0, in_ready=1.
- Saturation: CNT_W=3, 10 erroneous words → word_cnt and corr_cnt stop at 7.
